dvi_pattern_sequencer: RTL and testbench
========================================

Name: dvi_pattern_sequencer

Overview:
- Controller that sequences the RGB timing generator and drives its pixel data for DVI testing.
- Starts and stops the generator through its enable/stopped handshake, and counts frames on the generator's vs output.
- Switches among four test patterns at frame boundaries, either automatically or from a host select.
- Produces registered RGB aligned to delayed copies of hs/vs/de, which feed the TMDS encoder stage.

Parameters:
- PIXELS_H, 800, active width; must match the generator.
- PIXELS_V, 600, active height; must match the generator.
- FRAMES_PER_PATTERN, 60, frames shown per pattern in auto mode; legal range 1..65535.
- BAR_W, PIXELS_H/8, colour-bar width in pixels.

Ports:
- pixelClk  in  1  pixel clock; sole clock.
- resetN  in  1  asynchronous active-low reset.
- run  in  1  level request to output video.
- autoCycle  in  1  1: advance pattern every FRAMES_PER_PATTERN frames; 0: use patternSel.
- patternSel  in  2  manual pattern index.
- genEnable  out  1  to generator enable.
- genStopped  in  1  from generator stopped.
- genHs, genVs, genDe  in  1 each  generator timing outputs.
- pixelX  in  10  generator X coordinate.
- pixelY  in  10  generator Y coordinate.
- hsOut, vsOut, deOut  out  1 each  timing delayed by 1 cycle.
- red, green, blue  out  8 each  pixel data aligned with deOut.
- busy  out  1  high while state is not IDLE.
- pattern  out  2  pattern currently displayed.
- frameCount  out  16  frames counted since entering RUN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, genEnable=0, hsOut=vsOut=1, deOut=0.
  - rgb=0, pattern=0, frameCount=0, busy=0.
  - The internal frame-in-pattern counter and the vs history register also reset; vs history resets to 1.
- FSM states and transitions:
  - IDLE: genEnable=0. Go to START when run=1 and genStopped=1.
  - START: genEnable=1. Go to RUN on the first cycle genStopped=0.
  - RUN: genEnable=1. Go to DRAIN when run=0.
  - DRAIN: genEnable=0. Go to IDLE when genStopped=1. The generator finishes the current frame before it stops; DRAIN may last up to one full frame.
  - If run returns to 1 during DRAIN, stay in DRAIN until stopped, then restart through IDLE.
- Frame event:
  - Defined as genVs 1→0, taken on a registered edge detect.
  - Counted only in RUN and DRAIN.
  - frameCount increments on each event, saturates at 16'hFFFF, and clears on IDLE→START.
- Pattern update happens only on a frame event:
  - Auto mode: on the event where frame-in-pattern == FRAMES_PER_PATTERN-1, pattern ← pattern+1 (wraps 3→0) and the counter ← 0; otherwise the counter increments.
  - Manual mode: pattern ← patternSel on every event; the counter is held at 0.
  - Changing autoCycle mid-frame has no effect until the next event.
- Pixel data: combinational from pattern, pixelX and pixelY, then registered. Latency is 1 cycle, with the same register stage as hsOut/vsOut/deOut.
  - 0 colour bars: bar index = pixelX/BAR_W, saturated at 7. Bars in order: white, yellow, cyan, green, magenta, red, blue, black, using 8'hFF/8'h00 components.
  - 1 gradient: red=pixelX[7:0], green=pixelY[7:0], blue=frameCount[7:0].
  - 2 checker: white when pixelX[5]^pixelY[5]=1, else black.
  - 3 solid grey: all channels 8'h80.
  - When genDe=0 the registered rgb is 0.
- Outside RUN/DRAIN: hsOut/vsOut pass genHs/genVs through the delay register, and deOut=0.

Decomposition:
- Shared package dvi_test_pkg holds:
  - pattern index constants PAT_BARS=0, PAT_GRAD=1, PAT_CHECK=2, PAT_GREY=3;
  - FSM state encoding;
  - 24-bit colour constants for the eight bars.
- One sub-module, dvi_pattern_rom: combinational pattern/x/y→rgb lookup. The sequencer instantiates it and registers its output.

Test Plan:
- Reset then run=1 with the generator model stopped:
  - genEnable rises 1 cycle after run.
  - busy=1.
  - State reaches RUN when genStopped falls.
- Auto mode, FRAMES_PER_PATTERN=2: pattern reads 0,0,1,1,2,2,3,3,0 across 9 consecutive frame events; frameCount=9.
- Manual mode with patternSel=2 written mid-frame: pattern stays old until the next genVs fall, then reads 2.
- Pattern 0 at pixelX=0,100,700 (BAR_W=100), genDe=1: one cycle later rgb = FFFFFF, FFFF00, 000000, with deOut=1.
- run=0 mid-frame:
  - genEnable drops the next cycle.
  - busy stays 1 until genStopped=1, then IDLE with busy=0.
  - A run pulse during DRAIN does not reassert genEnable before genStopped=1.
- Assert resetN=0 during RUN with de active: outputs go to reset values immediately (asynchronously), without waiting for a pixelClk edge.

Source files
------------

// File: rtl/dvi_test_pkg.sv
// Shared types and constants for the DVI test-pattern sequencer.
package dvi_test_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CHAN_W  = 8;
  localparam int unsigned PAT_W   = 2;
  localparam int unsigned FCNT_W  = 16;

  localparam logic [PAT_W-1:0] PAT_BARS  = 2'd0;
  localparam logic [PAT_W-1:0] PAT_GRAD  = 2'd1;
  localparam logic [PAT_W-1:0] PAT_CHECK = 2'd2;
  localparam logic [PAT_W-1:0] PAT_GREY  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [CHAN_W-1:0] red;
    logic [CHAN_W-1:0] green;
    logic [CHAN_W-1:0] blue;
  } rgb_t;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_GREY    = 24'h808080;

  // Colour of bar idx, left (white) to right (black).
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    c = COL_BLACK;
    case (idx)
      3'd0: c = COL_WHITE;
      3'd1: c = COL_YELLOW;
      3'd2: c = COL_CYAN;
      3'd3: c = COL_GREEN;
      3'd4: c = COL_MAGENTA;
      3'd5: c = COL_RED;
      3'd6: c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvi_pattern_sequencer_if.sv
// Host, generator and TMDS-side signals of the pattern sequencer.
interface dvi_pattern_sequencer_if;
  import dvi_test_pkg::*;

  logic                run;
  logic                autoCycle;
  logic [PAT_W-1:0]    patternSel;
  logic                genEnable;
  logic                genStopped;
  logic                genHs;
  logic                genVs;
  logic                genDe;
  logic [COORD_W-1:0]  pixelX;
  logic [COORD_W-1:0]  pixelY;
  logic                hsOut;
  logic                vsOut;
  logic                deOut;
  logic [CHAN_W-1:0]   red;
  logic [CHAN_W-1:0]   green;
  logic [CHAN_W-1:0]   blue;
  logic                busy;
  logic [PAT_W-1:0]    pattern;
  logic [FCNT_W-1:0]   frameCount;

  modport master (
    input  run, autoCycle, patternSel, genStopped, genHs, genVs, genDe, pixelX, pixelY,
    output genEnable, hsOut, vsOut, deOut, red, green, blue, busy, pattern, frameCount
  );

  modport slave (
    output run, autoCycle, patternSel, genStopped, genHs, genVs, genDe, pixelX, pixelY,
    input  genEnable, hsOut, vsOut, deOut, red, green, blue, busy, pattern, frameCount
  );
endinterface

// File: rtl/dvi_pattern_rom.sv
// Combinational pattern/x/y to RGB lookup.
module dvi_pattern_rom
  import dvi_test_pkg::*;
#(
  parameter int unsigned PIXELS_H = 800,
  parameter int unsigned PIXELS_V = 600,
  parameter int unsigned BAR_W    = PIXELS_H / 8
) (
  input  logic [PAT_W-1:0]   pattern,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [CHAN_W-1:0]  frame_lsb,
  output rgb_t               rgb_c
);

  localparam int unsigned BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;

  int unsigned bar_raw;
  logic [2:0]  bar_sel;
  logic        in_area;

  // Pattern lookup; coordinates outside the active area are blanked.
  always_comb begin
    rgb_c   = '0;
    bar_raw = 32'(x) / BAR_DIV;
    bar_sel = (bar_raw > 32'd7) ? 3'd7 : 3'(bar_raw);
    in_area = (32'(x) < PIXELS_H) && (32'(y) < PIXELS_V);
    case (pattern)
      PAT_BARS:  rgb_c = rgb_t'(bar_colour(bar_sel));
      PAT_GRAD:  rgb_c = '{red: x[7:0], green: y[7:0], blue: frame_lsb};
      PAT_CHECK: rgb_c = rgb_t'((x[5] ^ y[5]) ? COL_WHITE : COL_BLACK);
      default:   rgb_c = rgb_t'(COL_GREY);
    endcase
    if (!in_area) rgb_c = '0;
  end

endmodule

// File: rtl/dvi_pattern_sequencer.sv
// Sequences the RGB timing generator and drives its pixel data for DVI testing.
module dvi_pattern_sequencer
  import dvi_test_pkg::*;
#(
  parameter int unsigned PIXELS_H           = 800,
  parameter int unsigned PIXELS_V           = 600,
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned BAR_W              = PIXELS_H / 8
) (
  input logic                     pixelClk,
  input logic                     resetN,
  dvi_pattern_sequencer_if.master bus
);

  localparam logic [FCNT_W-1:0] FIP_LAST = FCNT_W'(FRAMES_PER_PATTERN - 1);

  state_t             state, state_nx;
  logic               gen_enable_nx, busy_nx;
  logic               gen_enable_q, busy_q;
  logic               vs_hist_q;
  logic               active_c, frame_evt_c, de_eff_c;
  logic [FCNT_W-1:0]  frame_cnt_q, fip_cnt_q;
  logic [PAT_W-1:0]   pattern_q;
  logic               hs_q, vs_q, de_q;
  rgb_t               rgb_q, pix_rgb_c;

  assign active_c    = (state == ST_RUN) || (state == ST_DRAIN);
  assign frame_evt_c = active_c && vs_hist_q && !bus.genVs;
  assign de_eff_c    = active_c && bus.genDe;

  // State register.
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next state plus next values of the registered control outputs.
  always_comb begin
    state_nx      = state;
    gen_enable_nx = 1'b0;
    busy_nx       = 1'b0;
    case (state)
      ST_IDLE:  if (bus.run && bus.genStopped) state_nx = ST_START;
      ST_START: if (!bus.genStopped)           state_nx = ST_RUN;
      ST_RUN:   if (!bus.run)                  state_nx = ST_DRAIN;
      ST_DRAIN: if (bus.genStopped)            state_nx = ST_IDLE;
      default:                                 state_nx = ST_IDLE;
    endcase
    gen_enable_nx = (state_nx == ST_START) || (state_nx == ST_RUN);
    busy_nx       = (state_nx != ST_IDLE);
  end

  // Registered control outputs.
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN) begin
      gen_enable_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      gen_enable_q <= gen_enable_nx;
      busy_q       <= busy_nx;
    end
  end

  // vs history for the falling-edge frame event.
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN) vs_hist_q <= 1'b1;
    else         vs_hist_q <= bus.genVs;
  end

  // Saturating frame counter, cleared when a new run starts.
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN)
      frame_cnt_q <= '0;
    else if ((state == ST_IDLE) && (state_nx == ST_START))
      frame_cnt_q <= '0;
    else if (frame_evt_c && (frame_cnt_q != '1))
      frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
  end

  // Pattern selection, updated only at frame boundaries.
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN) begin
      pattern_q <= PAT_BARS;
      fip_cnt_q <= '0;
    end else if (frame_evt_c) begin
      if (bus.autoCycle) begin
        if (fip_cnt_q == FIP_LAST) begin
          pattern_q <= pattern_q + PAT_W'(1);
          fip_cnt_q <= '0;
        end else begin
          fip_cnt_q <= fip_cnt_q + FCNT_W'(1);
        end
      end else begin
        pattern_q <= bus.patternSel;
        fip_cnt_q <= '0;
      end
    end
  end

  dvi_pattern_rom #(
    .PIXELS_H (PIXELS_H),
    .PIXELS_V (PIXELS_V),
    .BAR_W    (BAR_W)
  ) u_rom (
    .pattern   (pattern_q),
    .x         (bus.pixelX),
    .y         (bus.pixelY),
    .frame_lsb (frame_cnt_q[CHAN_W-1:0]),
    .rgb_c     (pix_rgb_c)
  );

  // One-cycle output stage shared by timing and pixel data.
  always_ff @(posedge pixelClk or negedge resetN) begin
    if (!resetN) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= bus.genHs;
      vs_q  <= bus.genVs;
      de_q  <= de_eff_c;
      rgb_q <= de_eff_c ? pix_rgb_c : '0;
    end
  end

  assign bus.genEnable  = gen_enable_q;
  assign bus.busy       = busy_q;
  assign bus.pattern    = pattern_q;
  assign bus.frameCount = frame_cnt_q;
  assign bus.hsOut      = hs_q;
  assign bus.vsOut      = vs_q;
  assign bus.deOut      = de_q;
  assign bus.red        = rgb_q.red;
  assign bus.green      = rgb_q.green;
  assign bus.blue       = rgb_q.blue;

endmodule

// File: tb/tb_dvi_pattern_sequencer.sv
// Directed bench for the DVI pattern sequencer.
module tb_dvi_pattern_sequencer;

  logic pixelClk;
  logic resetN;
  int   checks;
  int   failures;
  int   exp_pat [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

  dvi_pattern_sequencer_if bus ();

  dvi_pattern_sequencer #(
    .PIXELS_H           (800),
    .PIXELS_V           (600),
    .FRAMES_PER_PATTERN (2),
    .BAR_W              (100)
  ) dut (
    .pixelClk (pixelClk),
    .resetN   (resetN),
    .bus      (bus)
  );

  initial begin
    pixelClk = 1'b0;
    forever #5 pixelClk = ~pixelClk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pixelClk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_genEnable"},  32'(bus.genEnable), 32'd0);
    check({pfx, "_hsOut"},      32'(bus.hsOut), 32'd1);
    check({pfx, "_vsOut"},      32'(bus.vsOut), 32'd1);
    check({pfx, "_deOut"},      32'(bus.deOut), 32'd0);
    check({pfx, "_rgb"},        32'({bus.red, bus.green, bus.blue}), 32'h0);
    check({pfx, "_busy"},       32'(bus.busy), 32'd0);
    check({pfx, "_pattern"},    32'(bus.pattern), 32'd0);
    check({pfx, "_frameCount"}, 32'(bus.frameCount), 32'd0);
  endtask

  task automatic vs_pulse();
    bus.genVs = 1'b0;
    tick(1);
    bus.genVs = 1'b1;
    tick(1);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    resetN        = 1'b1;
    bus.run        = 1'b0;
    bus.autoCycle  = 1'b1;
    bus.patternSel = 2'd0;
    bus.genStopped = 1'b1;
    bus.genHs      = 1'b1;
    bus.genVs      = 1'b1;
    bus.genDe      = 1'b0;
    bus.pixelX     = 10'd0;
    bus.pixelY     = 10'd0;
    #3 resetN = 1'b0;
    tick(2);
    check_reset_values("reset");
    resetN = 1'b1;
    tick(1);

    // Start: generator enabled one cycle after run, de blanked until RUN.
    bus.run   = 1'b1;
    bus.genDe = 1'b1;
    tick(1);
    check("start_genEnable", 32'(bus.genEnable), 32'd1);
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_deOut", 32'(bus.deOut), 32'd0);
    bus.genStopped = 1'b0;
    tick(1);
    check("start_deOut_still0", 32'(bus.deOut), 32'd0);
    tick(1);
    check("run_deOut", 32'(bus.deOut), 32'd1);
    check("run_genEnable", 32'(bus.genEnable), 32'd1);

    // Auto cycling, two frames per pattern.
    for (int i = 0; i < 9; i++) begin
      check($sformatf("auto_pattern_%0d", i), 32'(bus.pattern), 32'(exp_pat[i]));
      vs_pulse();
    end
    check("auto_frameCount", 32'(bus.frameCount), 32'd9);
    check("auto_pattern_end", 32'(bus.pattern), 32'd0);

    // Manual select mid-frame takes effect only at the next vs fall.
    bus.autoCycle  = 1'b0;
    bus.patternSel = 2'd2;
    tick(3);
    check("manual_hold", 32'(bus.pattern), 32'd0);
    vs_pulse();
    check("manual_pattern2", 32'(bus.pattern), 32'd2);
    bus.pixelX = 10'd32;
    bus.pixelY = 10'd0;
    tick(1);
    check("check_white", 32'({bus.red, bus.green, bus.blue}), 32'hFFFFFF);
    bus.pixelY = 10'd32;
    tick(1);
    check("check_black", 32'({bus.red, bus.green, bus.blue}), 32'h000000);

    bus.patternSel = 2'd1;
    vs_pulse();
    bus.pixelX = 10'h123;
    bus.pixelY = 10'h045;
    tick(1);
    check("grad_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h23450B);

    bus.patternSel = 2'd3;
    vs_pulse();
    tick(1);
    check("grey_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h808080);

    // Colour bars at the bar boundaries.
    bus.patternSel = 2'd0;
    vs_pulse();
    check("bars_frameCount", 32'(bus.frameCount), 32'd13);
    bus.pixelY = 10'd10;
    bus.pixelX = 10'd0;
    tick(1);
    check("bar_x0", 32'({bus.red, bus.green, bus.blue}), 32'hFFFFFF);
    check("bar_x0_de", 32'(bus.deOut), 32'd1);
    bus.pixelX = 10'd100;
    tick(1);
    check("bar_x100", 32'({bus.red, bus.green, bus.blue}), 32'hFFFF00);
    bus.pixelX = 10'd250;
    tick(1);
    check("bar_x250", 32'({bus.red, bus.green, bus.blue}), 32'h00FFFF);
    bus.pixelX = 10'd700;
    tick(1);
    check("bar_x700", 32'({bus.red, bus.green, bus.blue}), 32'h000000);
    check("bar_x700_de", 32'(bus.deOut), 32'd1);
    bus.pixelX = 10'd0;
    bus.genDe  = 1'b0;
    tick(1);
    check("blank_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0);
    check("blank_de", 32'(bus.deOut), 32'd0);

    // Stop mid-frame, with a run request arriving during drain.
    bus.run = 1'b0;
    tick(1);
    check("drain_genEnable", 32'(bus.genEnable), 32'd0);
    check("drain_busy", 32'(bus.busy), 32'd1);
    bus.run = 1'b1;
    tick(2);
    check("drain_runpulse_genEnable", 32'(bus.genEnable), 32'd0);
    check("drain_runpulse_busy", 32'(bus.busy), 32'd1);
    bus.genStopped = 1'b1;
    tick(1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_genEnable", 32'(bus.genEnable), 32'd0);
    tick(1);
    check("restart_genEnable", 32'(bus.genEnable), 32'd1);
    check("restart_frameCount", 32'(bus.frameCount), 32'd0);
    bus.genStopped = 1'b0;
    bus.genDe      = 1'b1;
    tick(2);
    check("restart_deOut", 32'(bus.deOut), 32'd1);

    // Build up non-reset state, then reset asynchronously mid-cycle.
    bus.patternSel = 2'd3;
    vs_pulse();
    bus.genHs = 1'b0;
    tick(1);
    check("pre_reset_pattern", 32'(bus.pattern), 32'd3);
    check("pre_reset_frameCount", 32'(bus.frameCount), 32'd1);
    check("pre_reset_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h808080);
    check("pre_reset_hsOut", 32'(bus.hsOut), 32'd0);
    #2 resetN = 1'b0;
    #1;
    check_reset_values("async_reset");
    tick(1);
    resetN = 1'b1;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
